// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issues multiply/divide operations to the MDU, tracks the
// in-flight operation, stalls HI/LO-accessing D-stage instructions while the
// MDU is occupied, and keeps a watchdog plus two performance counters.
module mdu_issue_ctrl #(
    parameter int         MUL_LAT = 5,
    parameter int         DIV_LAT = 10,
    parameter int         WDOG    = 15,
    // Instruction-type codes; keep in step with the shared CONST.v encodings.
    parameter logic [5:0] T_MULT  = 6'd20,
    parameter logic [5:0] T_MULTU = 6'd21,
    parameter logic [5:0] T_MADD  = 6'd22,
    parameter logic [5:0] T_DIV   = 6'd23,
    parameter logic [5:0] T_DIVU  = 6'd24,
    parameter logic [5:0] T_MTHI  = 6'd25,
    parameter logic [5:0] T_MTLO  = 6'd26,
    parameter logic [5:0] T_MFHI  = 6'd27,
    parameter logic [5:0] T_MFLO  = 6'd28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  d_instr_type,
    input  logic [5:0]  e_instr_type,
    input  logic        e_valid,
    input  logic        flush,
    input  logic        mdu_busy,
    output logic        mdu_start,
    output logic [5:0]  mdu_instr_type,
    output logic        stall_d,
    output logic        wdog_err,
    output logic [31:0] perf_busy,
    output logic [15:0] perf_ops
);

    localparam int         WDW     = $clog2(WDOG + 1) + 1;
    localparam logic [WDW-1:0] WDOG_V  = WDOG[WDW-1:0];
    localparam logic [WDW-1:0] WDOG_M1 = WDOG_V - 1'b1;
    localparam logic [3:0] MUL_CNT = MUL_LAT[3:0];
    localparam logic [3:0] DIV_CNT = DIV_LAT[3:0];

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_div(input logic [5:0] t);
        return (t == T_DIV) || (t == T_DIVU);
    endfunction

    function automatic logic is_long(input logic [5:0] t);
        return (t == T_MULT) || (t == T_MULTU) || (t == T_MADD) || is_div(t);
    endfunction

    function automatic logic is_access(input logic [5:0] t);
        return is_long(t) || (t == T_MTHI) || (t == T_MTLO) ||
               (t == T_MFHI) || (t == T_MFLO);
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d, cnt_dec;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            err_q, err_d;
    logic [31:0]     pbusy_q, pbusy_d;
    logic [15:0]     pops_q, pops_d;
    logic            issue;

    // Issue only from IDLE, never on a flushed slot, never while reset is held.
    assign issue = reset & e_valid & is_long(e_instr_type) & ~flush & (state_q == IDLE);

    assign mdu_start      = issue;
    assign mdu_instr_type = (reset & e_valid & ~flush) ? e_instr_type : 6'h0;
    assign stall_d        = is_access(d_instr_type) & (issue | (state_q == RUN) | mdu_busy);
    assign wdog_err       = err_q;
    assign perf_busy      = pbusy_q;
    assign perf_ops       = pops_q;

    // Next-state logic: issue loads the latency, RUN counts down and waits for the MDU.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_dec = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        wdog_d  = wdog_q;
        err_d   = err_q;
        pbusy_d = pbusy_q;
        pops_d  = pops_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = RUN;
                    cnt_d   = is_div(e_instr_type) ? DIV_CNT : MUL_CNT;
                    wdog_d  = '0;
                    pops_d  = pops_q + 16'd1;
                end
            end
            RUN: begin
                // A flush here is ignored: the MDU cannot cancel an operation.
                cnt_d   = cnt_dec;
                pbusy_d = pbusy_q + 32'd1;
                if (wdog_q < WDOG_V) wdog_d = wdog_q + 1'b1;
                if (wdog_q >= WDOG_M1) err_d = 1'b1;
                // Leave once the countdown reaches zero and the MDU has dropped busy.
                if ((cnt_dec == 4'd0) && !mdu_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            pbusy_q <= 32'd0;
            pops_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            pbusy_q <= pbusy_d;
            pops_q  <= pops_d;
        end
    end

endmodule
